// File: rtl/pgm_sprite_scan_if.sv
// Signal bundle between the per-line sprite scanner and the video engine:
// scan control, sprite attribute RAM read port and line-list write port.
interface pgm_sprite_scan_if;
    logic        start;
    logic [8:0]  line;
    logic [10:1] sprite_addr;
    logic [15:0] sprite_dout;
    logic        ent_we;
    logic [4:0]  ent_idx;
    logic [57:0] ent_data;
    logic [8:0]  ent_yoff;
    logic        busy;
    logic        done;
    logic [5:0]  count;
    logic        overflow;

    // Scanner side
    modport master (
        input  start, line, sprite_dout,
        output sprite_addr, ent_we, ent_idx, ent_data, ent_yoff,
               busy, done, count, overflow
    );

    // Video engine side
    modport slave (
        output start, line, sprite_dout,
        input  sprite_addr, ent_we, ent_idx, ent_data, ent_yoff,
               busy, done, count, overflow
    );
endinterface

// File: rtl/pgm_sprite_scan.sv
// Per-scanline sprite list builder: walks attribute RAM five words per sprite
// and writes up to MAX_SPR compacted entries for sprites covering the line.
module pgm_sprite_scan #(
    parameter int MAX_SPR = 32,
    parameter int NUM_SPR = 204
) (
    input  logic               clk,
    input  logic               reset,
    pgm_sprite_scan_if.master  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

    localparam logic [9:0] LAST_ADDR = 10'(5 * NUM_SPR - 1);
    localparam logic [5:0] CAP       = 6'(MAX_SPR);

    state_t      state_reg, state_next;
    logic [2:0]  w_reg, w_next;
    logic [9:0]  addr_reg, addr_next;
    logic [8:0]  line_reg, line_next;
    logic [5:0]  count_reg, count_next;
    logic        ovf_reg, ovf_next;
    logic [15:0] word_reg [0:3];

    logic [10:0] d;
    logic        hit;
    logic [4:0]  width;
    logic        we;
    logic        ent_we_int;
    logic        unused_bits;

    // Signed distance from sprite top; bit 10 set means the line is above it.
    assign d     = {2'b00, line_reg} - word_reg[1][10:0];
    assign hit   = !d[10] && ({1'b0, d} < {3'b000, word_reg[0][15:11], 4'b0000});
    assign width = bus.sprite_dout[4:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            w_reg     <= '0;
            addr_reg  <= '0;
            line_reg  <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            for (int i = 0; i < 4; i++) word_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            w_reg     <= w_next;
            addr_reg  <= addr_next;
            line_reg  <= line_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            // RAM has one cycle of latency: word w-1 arrives while w is addressed
            if (state_reg == FETCH && w_reg != 3'd0 && !bus.start)
                word_reg[w_reg - 3'd1] <= bus.sprite_dout;
        end
    end

    always_comb begin
        state_next = state_reg;
        w_next     = w_reg;
        addr_next  = addr_reg;
        line_next  = line_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        we         = 1'b0;
        if (bus.start) begin
            state_next = FETCH;
            w_next     = '0;
            addr_next  = '0;
            line_next  = bus.line;
            count_next = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: ;
                FETCH: begin
                    if (w_reg == 3'd4) begin
                        state_next = EVAL;
                        w_next     = '0;
                    end else begin
                        w_next    = w_reg + 3'd1;
                        addr_next = addr_reg + 10'd1;
                    end
                end
                EVAL: begin
                    addr_next = addr_reg + 10'd1;
                    if (width == 5'd0) begin
                        state_next = DONE;
                    end else if (hit && count_reg == CAP) begin
                        ovf_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        if (hit) begin
                            we         = 1'b1;
                            count_next = count_reg + 6'd1;
                        end
                        state_next = (addr_reg == LAST_ADDR) ? DONE : FETCH;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // A reset landing on an EVAL cycle must not leak a write.
    assign ent_we_int      = we && !reset;
    assign bus.ent_we      = ent_we_int;
    assign bus.ent_idx     = ent_we_int ? count_reg[4:0] : 5'd0;
    assign bus.ent_yoff    = ent_we_int ? d[8:0] : 9'd0;
    assign bus.ent_data    = ent_we_int ?
        {word_reg[0][10:0], width, word_reg[0][15:11], word_reg[3][4:0],
         word_reg[2], word_reg[3][15:8], bus.sprite_dout[15:8]} : 58'd0;
    assign bus.sprite_addr = addr_reg;
    assign bus.busy        = (state_reg == FETCH) || (state_reg == EVAL);
    assign bus.done        = (state_reg == DONE);
    assign bus.count       = count_reg;
    assign bus.overflow    = ovf_reg;

    assign unused_bits = ^{bus.sprite_dout[7:5], word_reg[1][15:11], word_reg[3][7:5]};
endmodule

// File: doc/pgm_sprite_scan.md
# pgm_sprite_scan

Per-scanline sprite list builder for the PGM video pipeline. On each line-start pulse it walks sprite attribute RAM in order, finds sprites that cover the requested scanline, and writes up to 32 compacted entries into the video engine's `line_sprites` list. It sits directly upstream of the sprite fetch and render stage in `pgm_video`, and owns that block's sprite RAM read port during a scan.

## Interface
Parameters:
- MAX_SPR, 32: list capacity in entries; the index port width is sized for 32.
- NUM_SPR, 204: attribute RAM capacity in sprites (5 words each, 1020 of 1024 words).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a scan for `line`
- line  in  9  target screen line, 0..223; sampled on `start`
- sprite_addr  out  10 [10:1]  word address into sprite RAM
- sprite_dout  in  16  RAM data; valid exactly 1 cycle after `sprite_addr`
- ent_we  out  1  list write strobe
- ent_idx  out  5  list slot being written
- ent_data  out  58  {x[10:0], width[4:0], height[4:0], pal[4:0], code[15:0], x_zoom[7:0], y_zoom[7:0]}
- ent_yoff  out  9  row inside the sprite = line − y
- busy  out  1  high from the cycle after `start` until `done`
- done  out  1  one-cycle pulse at the end of a scan
- count  out  6  entries written in the last or current scan, 0..32
- overflow  out  1  set when a 33rd hit is found; cleared on `start`

## Operation
- Word layout per sprite n, base = 5n:
  - w0: [10:0] x (signed), [15:11] height in 16-line units
  - w1: [10:0] y (signed)
  - w2: code
  - w3: [4:0] pal, [15:8] x_zoom
  - w4: [4:0] width in 16-pixel units, [15:8] y_zoom
- States:
  - IDLE: waits for `start`.
  - FETCH: 5 cycles, w = 0..4. `sprite_addr` = base + w. Words 0..3 are captured one cycle after their address.
  - EVAL: 1 cycle. Word 4 is taken directly from `sprite_dout`, then hit or end is decided.
  - DONE: 1 cycle, pulses `done`, then returns to IDLE.
- End marker: width == 0 goes to DONE. The sprite is not written.
- Hit test: d = {2'b0, line} − y in 11-bit two's complement. A hit requires d ≥ 0 (bit 10 clear) and d < height·16, with d zero-extended to 12 bits for the compare.
  - height == 0 never hits but does not end the scan.
  - y values near the wrap (for example y = 0x7F0 = −16) are handled by the signed compare.
- On a hit with count < 32:
  - `ent_we`=1 for that EVAL cycle.
  - `ent_idx` = count[4:0]; `ent_data` and `ent_yoff` = d[8:0] are valid in the same cycle.
  - count increments.
- On a hit with count == 32: set overflow and go to DONE with no write.
- After sprite NUM_SPR−1 is evaluated, go to DONE.
- `start` while busy aborts the current scan and restarts from sprite 0. Count and overflow clear and the new `line` is latched. Slots already written are left as they are.

## Timing
- Reset values: sprite_addr=0, ent_we=0, ent_idx=0, ent_data=0, ent_yoff=0, busy=0, done=0, count=0, overflow=0, state IDLE.
- start at cycle T:
  - First FETCH is at T+1 with sprite_addr=0.
  - Sprite n EVAL is at T+6+6n.
- Cost is 6 cycles per sprite. Worst case, from start to done, is 6·204+2 = 1226 cycles.
  - The line period must exceed this.
  - Scans that end early (end marker or overflow) finish sooner.
- `done` is asserted the cycle after the final EVAL. `busy` drops in the same cycle `done` is high.
- `ent_we` is never asserted outside EVAL. Slots are written in ascending order with no gaps.
- `count` is stable from `done` until the next `start`.
- Reset mid-scan returns to IDLE on the next edge and clears all outputs. No write is issued in that cycle.

## Test plan
- Single hit: sprite0 = {x=100, h=1, y=10, code=0x1234, pal=3, w=2}, sprite1 width=0, line=15 -> one write at T+6, ent_idx=0, ent_yoff=5, code=0x1234; done at T+13; count=1.
- Boundaries: y=10, h=1; line=9, 10, 25, 26 -> hits only for 10 (yoff 0) and 25 (yoff 15).
- Negative y: y=0x7F0 (−16), h=2, line=5 -> hit, yoff=21. The same sprite with h=1 -> no hit.
- Overflow: 40 sprites all hitting line 0 -> 32 writes (idx 0..31), overflow=1, count=32, done one cycle after the 33rd EVAL.
- Skip and terminate: sprite0 h=0, sprite1 hits, sprite2 width=0 -> exactly one write with idx 0, done at T+19.
- Restart and reset: start again while sprite 3 is in FETCH -> next sprite_addr=0, count=0. Reset asserted in an EVAL cycle -> no ent_we, all outputs 0 next cycle.
